// File: rtl/pulse_mon_pkg.sv
// Shared types and widths for the pulse interval monitor.
package pulse_mon_pkg;

   localparam int unsigned CNT_W_DEF = 8;
   localparam int unsigned STAT_W    = 8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACQ    = 2'd1,
      ST_LOCKED = 2'd2,
      ST_LOST   = 2'd3
   } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; used for the status tallies.
module sat_counter #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] count
);

   logic [W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (inc && (count_q != {W{1'b1}})) begin
         count_d = count_q + W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) count_q <= '0;
      else        count_q <= count_d;
   end

   assign count = count_q;

endmodule

// File: rtl/pulse_interval_monitor.sv
// Measures spacing of incoming 1-cycle pulses, tracks lock and error status.
// Optional min/max interval tracking is enabled by defining PULSE_MON_MINMAX_EN.
module pulse_interval_monitor
   import pulse_mon_pkg::*;
#(
   parameter int unsigned EXP_N    = 10,
   parameter int unsigned TOL      = 0,
   parameter int unsigned LOCK_CNT = 3,
   parameter int unsigned CNT_W    = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              pulse_in,
   input  logic              clr,
   output logic [CNT_W-1:0]  interval,
   output logic              interval_valid,
   output logic              locked,
   output logic              early_err,
   output logic              late_err,
   output logic              timeout,
   output logic [STAT_W-1:0] good_count,
   output logic [STAT_W-1:0] err_count,
   output logic [CNT_W-1:0]  ivl_min,
   output logic [CNT_W-1:0]  ivl_max
);

   localparam int unsigned      RUN_W   = $clog2(LOCK_CNT + 1);
   localparam logic [CNT_W-1:0] LO_LIM  = CNT_W'(EXP_N - TOL);
   localparam logic [CNT_W-1:0] HI_LIM  = CNT_W'(EXP_N + TOL);
   localparam logic [CNT_W-1:0] TO_LIM  = CNT_W'(2 * EXP_N + TOL);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [RUN_W-1:0] RUN_TGT = RUN_W'(LOCK_CNT);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] ivl_cnt_q, ivl_cnt_d;
   logic [RUN_W-1:0] good_run_q, good_run_d;
   logic [CNT_W-1:0] interval_q, interval_d;
   logic             valid_q, valid_d;
   logic             early_q, early_d;
   logic             late_q, late_d;
   logic             timeout_q, timeout_d;
   logic             locked_q, locked_d;
   logic             good_inc_c, err_inc_c;
   logic             is_early_c, is_late_c;

   assign is_early_c = (ivl_cnt_q < LO_LIM);
   assign is_late_c  = (ivl_cnt_q > HI_LIM);

   // Next-state, measurement and strobe generation.
   always_comb begin
      state_d    = state_q;
      ivl_cnt_d  = (ivl_cnt_q == CNT_MAX) ? ivl_cnt_q : ivl_cnt_q + CNT_W'(1);
      good_run_d = good_run_q;
      interval_d = interval_q;
      valid_d    = 1'b0;
      early_d    = 1'b0;
      late_d     = 1'b0;
      timeout_d  = timeout_q;
      good_inc_c = 1'b0;
      err_inc_c  = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            ivl_cnt_d = '0;
            if (pulse_in) begin
               state_d    = ST_ACQ;
               good_run_d = '0;
               ivl_cnt_d  = CNT_W'(1);
            end
         end
         ST_ACQ, ST_LOCKED: begin
            if (pulse_in) begin
               ivl_cnt_d  = CNT_W'(1);
               interval_d = ivl_cnt_q;
               valid_d    = 1'b1;
               if (is_early_c || is_late_c) begin
                  early_d    = is_early_c;
                  late_d     = is_late_c;
                  err_inc_c  = 1'b1;
                  good_run_d = '0;
                  state_d    = ST_ACQ;
               end else begin
                  good_inc_c = 1'b1;
                  if (state_q == ST_ACQ) begin
                     good_run_d = good_run_q + RUN_W'(1);
                     if (good_run_d == RUN_TGT) state_d = ST_LOCKED;
                  end
               end
            end else if (ivl_cnt_q >= TO_LIM) begin
               state_d   = ST_LOST;
               timeout_d = 1'b1;
               err_inc_c = 1'b1;
            end
         end
         ST_LOST: begin
            if (pulse_in) begin
               timeout_d  = 1'b0;
               state_d    = ST_ACQ;
               good_run_d = '0;
               ivl_cnt_d  = CNT_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Clear wins over any same-cycle pulse.
      if (clr) begin
         state_d    = ST_IDLE;
         ivl_cnt_d  = '0;
         good_run_d = '0;
         interval_d = '0;
         valid_d    = 1'b0;
         early_d    = 1'b0;
         late_d     = 1'b0;
         timeout_d  = 1'b0;
         good_inc_c = 1'b0;
         err_inc_c  = 1'b0;
      end

      locked_d = (state_d == ST_LOCKED);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         ivl_cnt_q  <= '0;
         good_run_q <= '0;
         interval_q <= '0;
         valid_q    <= 1'b0;
         early_q    <= 1'b0;
         late_q     <= 1'b0;
         timeout_q  <= 1'b0;
         locked_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         ivl_cnt_q  <= ivl_cnt_d;
         good_run_q <= good_run_d;
         interval_q <= interval_d;
         valid_q    <= valid_d;
         early_q    <= early_d;
         late_q     <= late_d;
         timeout_q  <= timeout_d;
         locked_q   <= locked_d;
      end
   end

   sat_counter #(.W(STAT_W)) u_good_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (good_inc_c),
      .clr   (clr),
      .count (good_count)
   );

   sat_counter #(.W(STAT_W)) u_err_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (err_inc_c),
      .clr   (clr),
      .count (err_count)
   );

`ifdef PULSE_MON_MINMAX_EN
   logic [CNT_W-1:0] ivl_min_q, ivl_min_d;
   logic [CNT_W-1:0] ivl_max_q, ivl_max_d;

   // Extremes track every reported interval.
   always_comb begin
      ivl_min_d = ivl_min_q;
      ivl_max_d = ivl_max_q;
      if (clr) begin
         ivl_min_d = CNT_MAX;
         ivl_max_d = '0;
      end else if (valid_d) begin
         if (interval_d < ivl_min_q) ivl_min_d = interval_d;
         if (interval_d > ivl_max_q) ivl_max_d = interval_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ivl_min_q <= CNT_MAX;
         ivl_max_q <= '0;
      end else begin
         ivl_min_q <= ivl_min_d;
         ivl_max_q <= ivl_max_d;
      end
   end

   assign ivl_min = ivl_min_q;
   assign ivl_max = ivl_max_q;
`else
   assign ivl_min = '0;
   assign ivl_max = '0;
`endif

   assign interval       = interval_q;
   assign interval_valid = valid_q;
   assign early_err      = early_q;
   assign late_err       = late_q;
   assign timeout        = timeout_q;
   assign locked         = locked_q;

endmodule

// File: tb/tb_pulse_interval_monitor.sv
// Randomized and directed checks of pulse_interval_monitor (TOL=0 and TOL=1)
// against a timestamp-based reference model.
module tb_pulse_interval_monitor;

   localparam int EXP_N = 10;
   localparam int LOCK  = 3;
   localparam int SMAX  = 255;

   logic clk = 1'b0;
   logic rst_n;
   logic pulse_in;
   logic clr;

   logic [7:0] ivl0, ivl1, gc0, gc1, ec0, ec1, mn0, mn1, mx0, mx1;
   logic       val0, val1, lk0, lk1, ea0, ea1, la0, la1, to0, to1;

   always #5 clk = ~clk;

   pulse_interval_monitor #(.EXP_N(EXP_N), .TOL(0), .LOCK_CNT(LOCK), .CNT_W(8)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .pulse_in(pulse_in), .clr(clr),
      .interval(ivl0), .interval_valid(val0), .locked(lk0),
      .early_err(ea0), .late_err(la0), .timeout(to0),
      .good_count(gc0), .err_count(ec0), .ivl_min(mn0), .ivl_max(mx0)
   );

   pulse_interval_monitor #(.EXP_N(EXP_N), .TOL(1), .LOCK_CNT(LOCK), .CNT_W(8)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .pulse_in(pulse_in), .clr(clr),
      .interval(ivl1), .interval_valid(val1), .locked(lk1),
      .early_err(ea1), .late_err(la1), .timeout(to1),
      .good_count(gc1), .err_count(ec1), .ivl_min(mn1), .ivl_max(mx1)
   );

   // mode: 0 idle, 1 acquiring, 2 locked, 3 lost
   typedef struct {
      int mode; int last; int run; int good; int err;
      int ivl; int valid; int early; int late; int tmo; int mn; int mx;
   } mdl_t;

   mdl_t m[2];
   int   tolv[2];
   int   n;
   int   checks;
   int   failures;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
      end
   endtask

   function automatic mdl_t mreset();
      mdl_t s;
      s = '{default: 0};
      s.mn = SMAX;
      return s;
   endfunction

   function automatic int sat_inc(input int v);
      return (v >= SMAX) ? SMAX : v + 1;
   endfunction

   // One clock edge of the specified behaviour, expressed with pulse timestamps.
   function automatic mdl_t mstep(input mdl_t si, input int tol, input bit p, input bit c, input int t);
      mdl_t s;
      int   el;
      s = si;
      if (c) return mreset();
      s.valid = 0; s.early = 0; s.late = 0;
      el = t - s.last;
      if (s.mode == 0) begin
         if (p) begin s.mode = 1; s.run = 0; s.last = t; end
      end else if (s.mode == 3) begin
         if (p) begin s.mode = 1; s.run = 0; s.last = t; s.tmo = 0; end
      end else if (p) begin
         s.valid = 1; s.ivl = el; s.last = t;
         if (el < s.mn) s.mn = el;
         if (el > s.mx) s.mx = el;
         if (el < EXP_N - tol || el > EXP_N + tol) begin
            s.early = (el < EXP_N - tol) ? 1 : 0;
            s.late  = (el > EXP_N + tol) ? 1 : 0;
            s.err = sat_inc(s.err); s.run = 0; s.mode = 1;
         end else begin
            s.good = sat_inc(s.good);
            if (s.mode == 1) begin
               s.run++;
               if (s.run == LOCK) s.mode = 2;
            end
         end
      end else if (el == 2 * EXP_N + tol) begin
         s.mode = 3; s.tmo = 1; s.err = sat_inc(s.err);
      end
      return s;
   endfunction

   task automatic cmp_all();
      for (int k = 0; k < 2; k++) begin
         logic [7:0] gi, gg, ge, gmn, gmx;
         logic       gv, gl, gea, gla, gt;
         int         emn, emx;
         if (k == 0) begin
            gi = ivl0; gv = val0; gl = lk0; gea = ea0; gla = la0; gt = to0;
            gg = gc0; ge = ec0; gmn = mn0; gmx = mx0;
         end else begin
            gi = ivl1; gv = val1; gl = lk1; gea = ea1; gla = la1; gt = to1;
            gg = gc1; ge = ec1; gmn = mn1; gmx = mx1;
         end
`ifdef PULSE_MON_MINMAX_EN
         emn = m[k].mn; emx = m[k].mx;
`else
         emn = 0; emx = 0;
`endif
         chk($sformatf("d%0d.interval", k), 32'(gi), m[k].ivl);
         chk($sformatf("d%0d.valid", k), 32'(gv), m[k].valid);
         chk($sformatf("d%0d.locked", k), 32'(gl), (m[k].mode == 2) ? 1 : 0);
         chk($sformatf("d%0d.early", k), 32'(gea), m[k].early);
         chk($sformatf("d%0d.late", k), 32'(gla), m[k].late);
         chk($sformatf("d%0d.timeout", k), 32'(gt), m[k].tmo);
         chk($sformatf("d%0d.good", k), 32'(gg), m[k].good);
         chk($sformatf("d%0d.err", k), 32'(ge), m[k].err);
         chk($sformatf("d%0d.min", k), 32'(gmn), emn);
         chk($sformatf("d%0d.max", k), 32'(gmx), emx);
      end
   endtask

   task automatic step(input bit p, input bit c);
      pulse_in = p;
      clr      = c;
      @(posedge clk);
      for (int k = 0; k < 2; k++) m[k] = mstep(m[k], tolv[k], p, c, n);
      n++;
      #1;
      cmp_all();
   endtask

   // Pulses k cycles after the previous one.
   task automatic gap(input int k);
      for (int i = 1; i < k; i++) step(1'b0, 1'b0);
      step(1'b1, 1'b0);
   endtask

   task automatic async_reset();
      #3;
      rst_n = 1'b0;
      m[0] = mreset();
      m[1] = mreset();
      #1;
      cmp_all();
      pulse_in = 1'b0;
      clr      = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cmp_all();
   endtask

   initial begin
      checks = 0; failures = 0; n = 0;
      tolv[0] = 0; tolv[1] = 1;
      m[0] = mreset(); m[1] = mreset();
      rst_n = 1'b0; pulse_in = 1'b0; clr = 1'b0;
      #1;
      cmp_all();
      @(posedge clk); @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Steady 10-cycle stream reaches lock on the 4th pulse.
      for (int i = 0; i < 4; i++) gap(EXP_N);
      chk("lock_locked", 32'(lk0), 1);
      chk("lock_good", 32'(gc0), 3);
      chk("lock_err", 32'(ec0), 0);
      chk("lock_ivl", 32'(ivl0), 10);

      // Early pulse drops lock, then relock.
      gap(7);
      chk("early_strobe", 32'(ea0), 1);
      chk("early_ivl", 32'(ivl0), 7);
      chk("early_unlock", 32'(lk0), 0);
      chk("early_err", 32'(ec0), 1);
      for (int i = 0; i < 3; i++) gap(EXP_N);
      chk("relock", 32'(lk0), 1);

      // Missing pulses: LOST exactly when the counter reaches 20.
      for (int i = 0; i < 19; i++) step(1'b0, 1'b0);
      chk("pre_timeout", 32'(to0), 0);
      step(1'b0, 1'b0);
      chk("timeout_set", 32'(to0), 1);
      chk("timeout_err", 32'(ec0), 2);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0);
      step(1'b1, 1'b0);
      chk("timeout_clr", 32'(to0), 0);
      chk("lost_novalid", 32'(val0), 0);

      // Tolerance edges on the TOL=1 instance.
      gap(9);
      chk("tol_9_early1", 32'(ea1), 0);
      chk("tol_9_early0", 32'(ea0), 1);
      gap(11);
      chk("tol_11_late1", 32'(la1), 0);
      gap(10);
      gap(12);
      chk("tol_12_late1", 32'(la1), 1);

      // Clear with a coincident pulse while locked.
      for (int i = 0; i < 4; i++) gap(EXP_N);
      chk("pre_clr_lock", 32'(lk0), 1);
      step(1'b1, 1'b1);
      chk("clr_locked", 32'(lk0), 0);
      chk("clr_good", 32'(gc0), 0);
      gap(EXP_N);
      chk("clr_first_novalid", 32'(val0), 0);

      // Error tally saturation.
      for (int i = 0; i < 300; i++) gap(5);
      chk("err_sat0", 32'(ec0), 255);
      chk("err_sat1", 32'(ec1), 255);

      // Asynchronous reset mid-interval.
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
      async_reset();

      // Randomized intervals with occasional clears.
      for (int i = 0; i < 400; i++) begin
         int g;
         g = int'($urandom_range(1, 24));
         for (int j = 1; j < g; j++) step(1'b0, ($urandom_range(0, 99) == 0));
         step(1'b1, ($urandom_range(0, 29) == 0));
      end
      gap(EXP_N);
      async_reset();
      gap(EXP_N);
      chk("post_reset_novalid", 32'(val0), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
